// File: rtl/multicycle_ctrl.sv
// Five-state multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB sharing one
// memory port via req/ready, with an optional wait timeout that sets a sticky err.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_byte,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src_imm,
  output logic       ext_zero,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_addi;
  logic is_lw, is_lb, is_sw, is_sb, is_beq, is_j, is_jal;
  logic is_load, is_store, is_byte, is_ialu, is_rtype, to_exec, wait_hit;

  assign is_r     = (opcode == 6'b000000);
  assign is_addu  = is_r && (funct == 6'b100001);
  assign is_subu  = is_r && (funct == 6'b100011);
  assign is_jr    = is_r && (funct == 6'b001000);
  assign is_ori   = (opcode == 6'b001101);
  assign is_lui   = (opcode == 6'b001111);
  assign is_addi  = (opcode == 6'b001000);
  assign is_lw    = (opcode == 6'b100011);
  assign is_lb    = (opcode == 6'b100000);
  assign is_sw    = (opcode == 6'b101011);
  assign is_sb    = (opcode == 6'b101000);
  assign is_beq   = (opcode == 6'b000100);
  assign is_j     = (opcode == 6'b000010);
  assign is_jal   = (opcode == 6'b000011);
  assign is_load  = is_lw | is_lb;
  assign is_store = is_sw | is_sb;
  assign is_byte  = is_lb | is_sb;
  assign is_ialu  = is_ori | is_lui | is_addi;
  assign is_rtype = is_addu | is_subu;
  assign to_exec  = is_rtype | is_ialu | is_load | is_store | is_beq;
  assign wait_hit = (WAIT_MAX != 0) && (cnt_q == CNT_W'(WAIT_MAX));

  assign state = state_q;
  assign err   = err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_byte    = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    wd_sel      = 2'd0;
    alu_src_imm = 1'b0;
    ext_zero    = 1'b0;
    alu_op      = 3'd0;
    instr_done  = 1'b0;

    // Shared wait accounting for FETCH and MEM; a timeout abandons to FETCH.
    if ((state_q == FETCH) || (state_q == MEM)) begin
      if (mem_ready) begin
        cnt_d = '0;
      end else if (wait_hit) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = FETCH;
      end else if (WAIT_MAX != 0) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (is_j || is_jal) begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          state_d    = FETCH;
          if (is_jal) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            wd_sel    = 2'd2;
          end
        end else if (is_jr) begin
          pc_write   = 1'b1;
          pc_src     = 2'd3;
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (to_exec) begin
          state_d = EXEC;
        end else begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      EXEC: begin
        if (is_subu) begin
          alu_op  = 3'd1;
          state_d = WB;
        end else if (is_addu) begin
          state_d = WB;
        end else if (is_ori) begin
          alu_op      = 3'd2;
          alu_src_imm = 1'b1;
          ext_zero    = 1'b1;
          state_d     = WB;
        end else if (is_lui) begin
          alu_op      = 3'd3;
          alu_src_imm = 1'b1;
          state_d     = WB;
        end else if (is_addi) begin
          alu_src_imm = 1'b1;
          state_d     = WB;
        end else if (is_load || is_store) begin
          alu_src_imm = 1'b1;
          state_d     = MEM;
        end else begin
          alu_op     = 3'd1;
          instr_done = is_beq;
          state_d    = FETCH;
          if (is_beq && zero) begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
          end
        end
      end
      MEM: begin
        mem_req     = 1'b1;
        addr_sel    = 1'b1;
        mem_we      = is_store;
        mem_byte    = is_byte;
        alu_src_imm = 1'b1;
        if (mem_ready) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype ? 2'd1 : 2'd0;
        wd_sel     = is_load ? 2'd1 : 2'd0;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (!reset_n) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_byte    = 1'b0;
      addr_sel    = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;
      reg_write   = 1'b0;
      reg_dst     = 2'd0;
      wd_sel      = 2'd0;
      alu_src_imm = 1'b0;
      ext_zero    = 1'b0;
      alu_op      = 3'd0;
      instr_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: two controllers (wait-forever and WAIT_MAX=4) driven in lockstep.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  logic       a_mem_req, a_mem_we, a_mem_byte, a_addr_sel, a_ir_write, a_pc_write;
  logic [1:0] a_pc_src, a_reg_dst, a_wd_sel;
  logic       a_reg_write, a_alu_src_imm, a_ext_zero, a_instr_done, a_err;
  logic [2:0] a_alu_op, a_state;
  logic       b_mem_req, b_mem_we, b_mem_byte, b_addr_sel, b_ir_write, b_pc_write;
  logic [1:0] b_pc_src, b_reg_dst, b_wd_sel;
  logic       b_reg_write, b_alu_src_imm, b_ext_zero, b_instr_done, b_err;
  logic [2:0] b_alu_op, b_state;
  logic [18:0] a_ctl, b_ctl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_MAX(0), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_byte(a_mem_byte),
    .addr_sel(a_addr_sel), .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .reg_write(a_reg_write), .reg_dst(a_reg_dst), .wd_sel(a_wd_sel),
    .alu_src_imm(a_alu_src_imm), .ext_zero(a_ext_zero), .alu_op(a_alu_op),
    .instr_done(a_instr_done), .err(a_err), .state(a_state)
  );

  multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_byte(b_mem_byte),
    .addr_sel(b_addr_sel), .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .reg_write(b_reg_write), .reg_dst(b_reg_dst), .wd_sel(b_wd_sel),
    .alu_src_imm(b_alu_src_imm), .ext_zero(b_ext_zero), .alu_op(b_alu_op),
    .instr_done(b_instr_done), .err(b_err), .state(b_state)
  );

  assign a_ctl = {a_mem_req, a_mem_we, a_mem_byte, a_addr_sel, a_ir_write, a_pc_write,
                  a_pc_src, a_reg_write, a_reg_dst, a_wd_sel, a_alu_src_imm, a_ext_zero,
                  a_alu_op, a_instr_done};
  assign b_ctl = {b_mem_req, b_mem_we, b_mem_byte, b_addr_sel, b_ir_write, b_pc_write,
                  b_pc_src, b_reg_write, b_reg_dst, b_wd_sel, b_alu_src_imm, b_ext_zero,
                  b_alu_op, b_instr_done};

  // Argument order: req we byte asel irw pcw pcs rw rdst wds imm ext aop done
  function automatic logic [18:0] mk(input int req, we, byt, asel, irw, pcw, pcs, rw,
                                     rdst, wds, imm, ext, aop, done);
    return {1'(req), 1'(we), 1'(byt), 1'(asel), 1'(irw), 1'(pcw), 2'(pcs), 1'(rw),
            2'(rdst), 2'(wds), 1'(imm), 1'(ext), 3'(aop), 1'(done)};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [2:0]  st;
    logic [18:0] ctl;
  } vec_t;

  vec_t vecs[$];

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_LB = 6'b100000,
                         OP_SW = 6'b101011, OP_SB = 6'b101000, OP_BEQ = 6'b000100,
                         OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_JR = 6'b001000,
                         FN_BAD = 6'b100000;

  logic [18:0] cF, cFW, cZ, cWBR, cWBI, cWBL, cMEMA;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic mr, input logic [2:0] st, input logic [18:0] c);
    vecs.push_back('{op, fn, z, mr, st, c});
  endtask

  // Apply inputs after the rising edge, compare both DUTs at the falling edge.
  task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [2:0] st,
                      input logic [18:0] c, input logic ea, input logic eb);
    opcode = op; funct = fn; zero = z; mem_ready = mr;
    @(negedge clk);
    chk({nm, ".a.state"}, 32'(a_state), 32'(st));
    chk({nm, ".a.ctrl"},  32'(a_ctl),   32'(c));
    chk({nm, ".a.err"},   32'(a_err),   32'(ea));
    chk({nm, ".b.state"}, 32'(b_state), 32'(st));
    chk({nm, ".b.ctrl"},  32'(b_ctl),   32'(c));
    chk({nm, ".b.err"},   32'(b_err),   32'(eb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    cZ    = '0;
    cF    = mk(1,0,0,0,1,1,0,0,0,0,0,0,0,0);
    cFW   = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    cWBR  = mk(0,0,0,0,0,0,0,1,1,0,0,0,0,1);
    cWBI  = mk(0,0,0,0,0,0,0,1,0,0,0,0,0,1);
    cWBL  = mk(0,0,0,0,0,0,0,1,0,1,0,0,0,1);
    cMEMA = mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0);

    // lw: 5 cycles
    add(OP_LW, 6'd0, 0, 1, 3'd0, cF);
    add(OP_LW, 6'd0, 0, 1, 3'd1, cZ);
    add(OP_LW, 6'd0, 0, 1, 3'd2, cMEMA);
    add(OP_LW, 6'd0, 0, 1, 3'd3, mk(1,0,0,1,0,0,0,0,0,0,1,0,0,0));
    add(OP_LW, 6'd0, 0, 1, 3'd4, cWBL);
    // addu, subu
    add(OP_R, FN_ADDU, 0, 1, 3'd0, cF);
    add(OP_R, FN_ADDU, 0, 1, 3'd1, cZ);
    add(OP_R, FN_ADDU, 0, 1, 3'd2, cZ);
    add(OP_R, FN_ADDU, 0, 1, 3'd4, cWBR);
    add(OP_R, FN_SUBU, 0, 1, 3'd0, cF);
    add(OP_R, FN_SUBU, 0, 1, 3'd1, cZ);
    add(OP_R, FN_SUBU, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
    add(OP_R, FN_SUBU, 0, 1, 3'd4, cWBR);
    // ori, lui, addi (funct deliberately non-zero on I-type)
    add(OP_ORI, FN_JR, 0, 1, 3'd0, cF);
    add(OP_ORI, FN_JR, 0, 1, 3'd1, cZ);
    add(OP_ORI, FN_JR, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,0,0,0,1,1,2,0));
    add(OP_ORI, FN_JR, 0, 1, 3'd4, cWBI);
    add(OP_LUI, 6'd0, 0, 1, 3'd0, cF);
    add(OP_LUI, 6'd0, 0, 1, 3'd1, cZ);
    add(OP_LUI, 6'd0, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,0,0,0,1,0,3,0));
    add(OP_LUI, 6'd0, 0, 1, 3'd4, cWBI);
    add(OP_ADDI, FN_JR, 0, 1, 3'd0, cF);
    add(OP_ADDI, FN_JR, 0, 1, 3'd1, cZ);
    add(OP_ADDI, FN_JR, 0, 1, 3'd2, cMEMA);
    add(OP_ADDI, FN_JR, 0, 1, 3'd4, cWBI);
    // beq taken / not taken
    add(OP_BEQ, 6'd0, 1, 1, 3'd0, cF);
    add(OP_BEQ, 6'd0, 1, 1, 3'd1, cZ);
    add(OP_BEQ, 6'd0, 1, 1, 3'd2, mk(0,0,0,0,0,1,1,0,0,0,0,0,1,1));
    add(OP_BEQ, 6'd0, 0, 1, 3'd0, cF);
    add(OP_BEQ, 6'd0, 0, 1, 3'd1, cZ);
    add(OP_BEQ, 6'd0, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,1));
    // jumps and NOPs: 2 cycles
    add(OP_JAL, 6'd0, 0, 1, 3'd0, cF);
    add(OP_JAL, 6'd0, 0, 1, 3'd1, mk(0,0,0,0,0,1,2,1,2,2,0,0,0,1));
    add(OP_J, 6'd0, 0, 1, 3'd0, cF);
    add(OP_J, 6'd0, 0, 1, 3'd1, mk(0,0,0,0,0,1,2,0,0,0,0,0,0,1));
    add(OP_R, FN_JR, 0, 1, 3'd0, cF);
    add(OP_R, FN_JR, 0, 1, 3'd1, mk(0,0,0,0,0,1,3,0,0,0,0,0,0,1));
    add(OP_BAD, 6'd0, 0, 1, 3'd0, cF);
    add(OP_BAD, 6'd0, 0, 1, 3'd1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    add(OP_R, FN_BAD, 0, 1, 3'd0, cF);
    add(OP_R, FN_BAD, 0, 1, 3'd1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    // sw, lb
    add(OP_SW, 6'd0, 0, 1, 3'd0, cF);
    add(OP_SW, 6'd0, 0, 1, 3'd1, cZ);
    add(OP_SW, 6'd0, 0, 1, 3'd2, cMEMA);
    add(OP_SW, 6'd0, 0, 1, 3'd3, mk(1,1,0,1,0,0,0,0,0,0,1,0,0,1));
    add(OP_LB, 6'd0, 0, 1, 3'd0, cF);
    add(OP_LB, 6'd0, 0, 1, 3'd1, cZ);
    add(OP_LB, 6'd0, 0, 1, 3'd2, cMEMA);
    add(OP_LB, 6'd0, 0, 1, 3'd3, mk(1,0,1,1,0,0,0,0,0,0,1,0,0,0));
    add(OP_LB, 6'd0, 0, 1, 3'd4, cWBL);

    // Reset held with mem_ready=1: outputs forced low, state FETCH
    reset_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.a.ctrl", 32'(a_ctl), 32'(cZ));
    chk("rst.a.state", 32'(a_state), 32'd0);
    chk("rst.b.err", 32'(b_err), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].mr,
           vecs[i].st, vecs[i].ctl, 1'b0, 1'b0);

    // sb with mem_ready low in DECODE/EXEC (ignored) and 3 wait cycles in MEM
    step("sb.f", OP_SB, 6'd0, 0, 1, 3'd0, cF, 0, 0);
    step("sb.d", OP_SB, 6'd0, 0, 0, 3'd1, cZ, 0, 0);
    step("sb.e", OP_SB, 6'd0, 0, 0, 3'd2, cMEMA, 0, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("sb.w%0d", i), OP_SB, 6'd0, 0, 0, 3'd3,
           mk(1,1,1,1,0,0,0,0,0,0,1,0,0,0), 0, 0);
    step("sb.m", OP_SB, 6'd0, 0, 1, 3'd3, mk(1,1,1,1,0,0,0,0,0,0,1,0,0,1), 0, 0);

    // Fetch timeout on the WAIT_MAX=4 instance; the other waits forever
    for (int i = 0; i < 5; i++)
      step($sformatf("to.w%0d", i), OP_SW, 6'd0, 0, 0, 3'd0, cFW, 0, 0);
    // Counter cleared by timeout: four more waits, ready on the fifth completes
    for (int i = 0; i < 4; i++)
      step($sformatf("to.r%0d", i), OP_SW, 6'd0, 0, 0, 3'd0, cFW, 0, 1);
    step("to.hit", OP_SW, 6'd0, 0, 1, 3'd0, cF, 0, 1);
    step("to.dec", OP_SW, 6'd0, 0, 0, 3'd1, cZ, 0, 1);
    step("to.exe", OP_SW, 6'd0, 0, 0, 3'd2, cMEMA, 0, 1);

    // Reset asserted mid-MEM of a store
    opcode = OP_SW; mem_ready = 1'b0;
    @(negedge clk);
    chk("mr.a.state", 32'(a_state), 32'd3);
    chk("mr.a.ctrl", 32'(a_ctl), 32'(mk(1,1,0,1,0,0,0,0,0,0,1,0,0,0)));
    chk("mr.b.err", 32'(b_err), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mr.rst.a.ctrl", 32'(a_ctl), 32'(cZ));
    chk("mr.rst.b.ctrl", 32'(b_ctl), 32'(cZ));
    chk("mr.rst.a.state", 32'(a_state), 32'd0);
    chk("mr.rst.b.state", 32'(b_state), 32'd0);
    chk("mr.rst.b.err", 32'(b_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
